// File: rtl/aes_pkg.sv
// Shared AES-128 constants, byte-level transforms and FSM state type for the
// iterative decryptor. Byte 0 of every 128-bit block sits in bits [127:120].
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_ADDKEY,
    ST_ROUND,
    ST_DONE
  } state_t;

  localparam logic [0:255][7:0] SBOX_TBL = {
    256'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:255][7:0] INV_SBOX_TBL = {
    256'h52096ad53036a538bf40a39e81f3d7fb_7ce339829b2fff87348e4344c4dee9cb,
    256'h547b9432a6c2233dee4c950b42fac34e_082ea16628d924b2765ba2496d8bd125,
    256'h72f8f66486689816d4a45ccc5d65b692_6c704850fdedb9da5e154657a78d9d84,
    256'h90d8ab008cbcd30af7e45805b8b34506_d02c1e8fca3f0f02c1afbd0301138a6b,
    256'h3a9111414f67dcea97f2cfcef0b4e673_96ac7422e7ad3585e2f937e81c75df6e,
    256'h47f11a711d29c5896fb7620eaa18be1b_fc563e4bc6d279209adbc0fe78cd5af4,
    256'h1fdda8338807c731b11210592780ec5f_60517fa919b54a0d2de57a9f93c99cef,
    256'ha0e03b4dae2af5b0c8ebbb3c83539961_172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TBL[a];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return INV_SBOX_TBL[a];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Row r of column c comes from column (c - r) mod 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [0:15][7:0] b;
    logic [0:15][7:0] o;
    b = s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[r + 4*c] = b[r + 4*((c - r + 4) % 4)];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [0:15][7:0] b;
    logic [0:15][7:0] o;
    b = s;
    for (int i = 0; i < 16; i++) o[i] = inv_sbox(b[i]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [0:15][7:0] b;
    logic [0:15][7:0] o;
    b = s;
    for (int c = 0; c < 4; c++) begin
      o[4*c+0] = gmul(b[4*c], 8'h0e) ^ gmul(b[4*c+1], 8'h0b) ^ gmul(b[4*c+2], 8'h0d) ^ gmul(b[4*c+3], 8'h09);
      o[4*c+1] = gmul(b[4*c], 8'h09) ^ gmul(b[4*c+1], 8'h0e) ^ gmul(b[4*c+2], 8'h0b) ^ gmul(b[4*c+3], 8'h0d);
      o[4*c+2] = gmul(b[4*c], 8'h0d) ^ gmul(b[4*c+1], 8'h09) ^ gmul(b[4*c+2], 8'h0e) ^ gmul(b[4*c+3], 8'h0b);
      o[4*c+3] = gmul(b[4*c], 8'h0b) ^ gmul(b[4*c+1], 8'h0d) ^ gmul(b[4*c+2], 8'h09) ^ gmul(b[4*c+3], 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule in either direction: forward
// (rk_i -> rk_i+1) or inverse (rk_i -> rk_i-1), sharing a single SubWord.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  input  logic         i_inv,
  output logic [127:0] o_key
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_p1, w_p2, w_p3;
  logic [31:0] w_sw, w_n0;

  assign {w_w0, w_w1, w_w2, w_w3} = i_key;

  // Inverse direction recovers the older words first, so SubWord sees w3' not w3.
  assign w_p3 = w_w3 ^ w_w2;
  assign w_p2 = w_w2 ^ w_w1;
  assign w_p1 = w_w1 ^ w_w0;
  assign w_sw = sub_word(rot_word(i_inv ? w_p3 : w_w3)) ^ {i_rcon, 24'h000000};
  assign w_n0 = w_w0 ^ w_sw;

  assign o_key = i_inv ? {w_n0, w_p1, w_p2, w_p3}
                       : {w_n0, w_w1 ^ w_n0, w_w2 ^ w_w1 ^ w_n0, w_w3 ^ w_w2 ^ w_w1 ^ w_n0};

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: one round per clock, round keys derived on the
// fly (forward expansion to rk10, then walked back to rk0).
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter int NR      = 10,
  parameter bit ZEROIZE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_decrypt_iter supports only NR = 10 (AES-128)");
  end

  state_t       r_state, w_state_nxt;
  logic [127:0] r_s, r_k;
  logic [3:0]   r_cnt;
  logic [3:0]   w_rc_idx;
  logic [127:0] w_key_nxt;
  logic [127:0] w_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_KEYEXP;
      end
      ST_KEYEXP: if (r_cnt == 4'd9) w_state_nxt = ST_ADDKEY;
      ST_ADDKEY: w_state_nxt = ST_ROUND;
      ST_ROUND:  if (r_cnt == 4'd0) w_state_nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Expansion uses rcon[cnt+1]; the inverse walk from rk_cnt uses rcon[cnt].
  assign w_rc_idx = (r_state == ST_KEYEXP) ? r_cnt + 4'd1 : r_cnt;

  aes_key_step u_key_step (
    .i_key  (r_k),
    .i_rcon (rcon(w_rc_idx)),
    .i_inv  (r_state != ST_KEYEXP),
    .o_key  (w_key_nxt)
  );

  assign w_t = inv_sub_bytes(inv_shift_rows(r_s)) ^ r_k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s   <= '0;
      r_k   <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_s   <= ciphertext;
          r_k   <= key;
          r_cnt <= 4'd0;
        end
        ST_KEYEXP: begin
          r_k   <= w_key_nxt;
          r_cnt <= r_cnt + 4'd1;
        end
        ST_ADDKEY: begin
          r_s   <= r_s ^ r_k;
          r_k   <= w_key_nxt;
          r_cnt <= 4'd9;
        end
        ST_ROUND: begin
          r_s <= (r_cnt != 4'd0) ? inv_mix_columns(w_t) : w_t;
          if (r_cnt != 4'd0) begin
            r_k   <= w_key_nxt;
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: if (out_ready && ZEROIZE) begin
          r_s   <= '0;
          r_k   <= '0;
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign plaintext = r_s;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: known-answer table, handshake/reset corner
// sequences, and random blocks checked against a behavioural AES encryptor.
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  aes_decrypt_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (forward AES from GF(2^8) arithmetic) ----
  logic [7:0] sb_m [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  st [16];
    logic [7:0]  tmp [16];
    logic [7:0]  rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]], sb_m[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sb_m[st[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) tmp[q + 4*c] = st[q + 4*((c + q) % 4)];
      for (int i = 0; i < 16; i++) st[i] = tmp[i];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          tmp[4*c]   = gm(st[4*c], 8'h02) ^ gm(st[4*c+1], 8'h03) ^ st[4*c+2] ^ st[4*c+3];
          tmp[4*c+1] = st[4*c] ^ gm(st[4*c+1], 8'h02) ^ gm(st[4*c+2], 8'h03) ^ st[4*c+3];
          tmp[4*c+2] = st[4*c] ^ st[4*c+1] ^ gm(st[4*c+2], 8'h02) ^ gm(st[4*c+3], 8'h03);
          tmp[4*c+3] = gm(st[4*c], 8'h03) ^ st[4*c+1] ^ st[4*c+2] ^ gm(st[4*c+3], 8'h02);
        end
        for (int i = 0; i < 16; i++) st[i] = tmp[i];
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller 1ns after the accepting edge, with junk on the inputs.
  task automatic send(input logic [127:0] ct, input logic [127:0] k);
    int g;
    g = 0;
    in_valid   = 1'b1;
    ciphertext = ct;
    key        = k;
    while (!in_ready && g < 60) begin
      tick();
      g++;
    end
    chk_int("accept_ready", int'(in_ready), 1);
    tick();
    in_valid   = 1'b0;
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    key        = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(input logic chk_rk, input logic [127:0] rk_exp, output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
      if (chk_rk && lat == 10) chk128("rk10_at_addkey", dut.r_k, rk_exp);
    end
    chk_int("out_valid_seen", int'(out_valid), 1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    logic         chk_rk;
    logic [127:0] rk10;
  } vec_t;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT_RT = 128'h0123456789abcdeffedcba9876543210;

  vec_t tbl [3];

  initial begin
    int lat;
    int dly;
    logic [127:0] rk, rp, rc;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
    key        = '0;
    build_sbox();

    tbl[0] = '{"fips_c1",   K_C1, CT_C1, PT_C1, 1'b0, '0};
    tbl[1] = '{"fips_b",    K_B,  CT_B,  PT_B,  1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[2] = '{"roundtrip", K_C1, aes_enc(PT_RT, K_C1), PT_RT, 1'b0, '0};

    // ---- reset state ----
    repeat (2) tick();
    chk_int("rst_in_ready", int'(in_ready), 1);
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk128("rst_plaintext", plaintext, '0);
    rst_n = 1'b1;
    tick();

    // ---- known-answer table ----
    for (int i = 0; i < 3; i++) begin
      send(tbl[i].ct, tbl[i].key);
      wait_out(tbl[i].chk_rk, tbl[i].rk10, lat);
      chk_int({tbl[i].name, "_latency"}, lat, 21);
      chk128({tbl[i].name, "_pt"}, plaintext, tbl[i].pt);
      take();
    end

    // ---- backpressure: output held, new input refused while in DONE ----
    send(CT_C1, K_C1);
    wait_out(1'b0, '0, lat);
    in_valid   = 1'b1;
    ciphertext = CT_B;
    key        = K_B;
    for (int i = 0; i < 5; i++) begin
      chk_int("bp_out_valid", int'(out_valid), 1);
      chk128("bp_plaintext", plaintext, PT_C1);
      chk_int("bp_in_ready", int'(in_ready), 0);
      tick();
    end
    take();
    chk_int("bp_release_in_ready", int'(in_ready), 1);
    chk_int("bp_release_out_valid", int'(out_valid), 0);
    chk128("bp_release_zeroized", plaintext, '0);
    in_valid = 1'b0;
    tick();

    // ---- asynchronous reset in ROUND with cnt=5 ----
    send(CT_C1, K_C1);
    repeat (15) tick();
    chk_int("midrst_cnt", int'(dut.r_cnt), 5);
    rst_n = 1'b0;
    #1;
    chk_int("midrst_in_ready", int'(in_ready), 1);
    chk_int("midrst_out_valid", int'(out_valid), 0);
    chk128("midrst_plaintext", plaintext, '0);
    tick();
    rst_n = 1'b1;
    tick();
    send(CT_C1, K_C1);
    wait_out(1'b0, '0, lat);
    chk_int("after_rst_latency", lat, 21);
    chk128("after_rst_pt", plaintext, PT_C1);
    take();

    // ---- back-to-back with out_ready tied high ----
    out_ready = 1'b1;
    send(CT_C1, K_C1);
    in_valid   = 1'b1;
    ciphertext = CT_B;
    key        = K_B;
    wait_out(1'b0, '0, lat);
    chk128("b2b_first_pt", plaintext, PT_C1);
    tick();
    chk_int("b2b_gap_in_ready", int'(in_ready), 1);
    chk128("b2b_gap_s_zero", dut.r_s, '0);
    chk128("b2b_gap_k_zero", dut.r_k, '0);
    tick();
    chk_int("b2b_second_accepted", int'(in_ready), 0);
    in_valid = 1'b0;
    wait_out(1'b0, '0, lat);
    chk_int("b2b_second_latency", lat, 21);
    chk128("b2b_second_pt", plaintext, PT_B);
    tick();
    out_ready = 1'b0;

    // ---- random blocks against the reference encryptor ----
    for (int n = 0; n < 20; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      rc = aes_enc(rp, rk);
      send(rc, rk);
      wait_out(1'b0, '0, lat);
      dly = $urandom_range(0, 3);
      repeat (dly) tick();
      chk128("random_pt", plaintext, rp);
      take();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
